ring_johnson_counter: RTL and testbench
=======================================

Name: ring_johnson_counter

Overview:
- Parametrised successor to the team's fixed 4-bit ring counter.
- Generates a one-hot ring sequence or a twisted-ring (Johnson) sequence of WIDTH bits.
- Supports shift direction, enable, parallel load, a wrap pulse and self-correction of illegal states.
- Used as a sequencer/phase generator feeding strobe and mux-select logic.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; count forced to HOME immediately on assertion
en  input  1  advance enable; count holds when 0
mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (inverted feedback)
dir  input  1  0 = shift towards MSB, 1 = shift towards LSB
load  input  1  synchronous parallel load strobe; priority over en
load_val  input  WIDTH  value written by load
count  output  WIDTH  current counter state (registered)
wrap  output  1  one-cycle pulse: count has just advanced into HOME
err  output  1  one-cycle pulse: illegal state was just corrected

Behaviour:
- HOME = {WIDTH-1 zeros, 1} (bit 0 set). HOME is legal in both modes.
- Reset (reset == 0, asynchronous): count = HOME, wrap = 0, err = 0.
  - Held while reset is low.
  - First update is on the first rising clk after reset goes high.
- Per-edge priority, highest first: load, then en, then hold.
- load = 1:
  - count <= load_val.
  - wrap <= 0, err <= 0.
  - No legality check on the load edge.
- load = 0, en = 1, count legal for current mode: advance.
  - Ring, dir = 0: count <= {count[W-2:0], count[W-1]}.
  - Ring, dir = 1: count <= {count[0], count[W-1:1]}.
  - Johnson, dir = 0: count <= {count[W-2:0], ~count[W-1]}.
  - Johnson, dir = 1: count <= {~count[0], count[W-1:1]}.
  - wrap <= 1 if the new count == HOME, else 0. err <= 0.
- load = 0, en = 1, count illegal for current mode: correct.
  - count <= HOME, err <= 1, wrap <= 0.
- load = 0, en = 0: count holds; wrap <= 0, err <= 0.
- Legality rules:
  - Ring: exactly one bit set (popcount == 1).
  - Johnson: at most one position i in 0..W-2 where count[i] != count[i+1]. This gives exactly 2*WIDTH legal states, including all-zeros and all-ones.
- Sequence periods: ring = WIDTH advances; Johnson = 2*WIDTH advances. wrap fires once per period in steady state.
- Mode or dir changes take effect on the next enabled edge.
  - If the current state is illegal in the new mode, that edge performs a correction, not an advance.
  - Example: ring 0100 is illegal in Johnson mode and corrects to HOME.
- Ring all-zeros (reachable only via load) is illegal and corrected; the counter never locks up.
- wrap and err are mutually exclusive and never asserted on a load edge or during reset.
- Reset asserted mid-sequence: outputs go to reset values without waiting for clk; no partial update.
- Latency: count, wrap and err are all registered and visible one clock after the qualifying edge inputs.

Test Plan:
- WIDTH=4, ring, dir=0, en=1 after reset release -> count 0001, 0010, 0100, 1000, 0001; wrap = 1 only in the cycle count returns to 0001; err = 0 throughout.
- WIDTH=4, Johnson, dir=0, en=1 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; wrap once per 8 advances. Repeat with dir=1 -> 0001, 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- Ring, load=1 with load_val=0110 -> count 0110, wrap = 0, err = 0. Next edge with en=1 -> count 0001, err = 1 for one cycle, wrap = 0. Next edge -> 0010, err = 0.
- Ring at count 0100, switch mode to 1, en=1 -> correction to 0001 with err = 1. Johnson at 0011, switch to ring -> correction. en=0 for 5 cycles -> count frozen, no pulses. load and en both high -> load wins.
- Mid-sequence (count 1000), drive reset low between clk edges -> count = 0001, wrap = err = 0 before the next clk edge; held until release.
- Parameter sweep WIDTH = 2, 5, 8, both modes and directions -> periods of WIDTH and 2*WIDTH; exhaustive load of all 2^WIDTH values (WIDTH ≤ 8) -> err pulses exactly for the illegal states defined above.

Source files
------------

// File: rtl/ring_johnson_counter.sv
// rtl/ring_johnson_counter.sv - parametrised ring / Johnson (twisted-ring) sequencer
//
// Purpose:
//   WIDTH-bit phase generator that rotates either a single one-hot bit (ring
//   mode) or a twisted-ring pattern (Johnson mode) in either direction.
//   Supports enable, parallel load, a wrap pulse on returning to HOME and
//   self-correction of states that are illegal for the current mode.
//   HOME is bit 0 set, all other bits clear, and is legal in both modes.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset, count forced to HOME
//   en       in   1      advance enable (count holds when low)
//   mode     in   1      0 = ring (one-hot rotate), 1 = Johnson
//   dir      in   1      0 = shift towards MSB, 1 = shift towards LSB
//   load     in   1      synchronous parallel load, wins over en
//   load_val in   WIDTH  value written by load
//   count    out  WIDTH  registered counter state
//   wrap     out  1      one-cycle pulse: count just advanced into HOME
//   err      out  1      one-cycle pulse: an illegal state was just corrected
//
// WIDTH must lie in 2..32.

module ring_johnson_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME    = WIDTH'(1);
  localparam logic [WIDTH-2:0] TR_ONE  = (WIDTH-1)'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-2:0] w_trans;
  logic             w_ring_legal;
  logic             w_john_legal;
  logic             w_legal;
  logic             w_fb_low;
  logic             w_fb_high;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;

  // Ring legality: exactly one bit set. x & (x-1) clears the lowest set bit,
  // so it is zero only for a power of two (or zero, excluded separately).
  assign w_ring_legal = (r_count != '0) &&
                        ((r_count & (r_count - CNT_ONE)) == '0);

  // Johnson legality: the neighbour-difference vector may hold at most one
  // set bit, i.e. the word is a single run of ones against a run of zeros.
  assign w_trans      = r_count[WIDTH-2:0] ^ r_count[WIDTH-1:1];
  assign w_john_legal = ((w_trans & (w_trans - TR_ONE)) == '0);

  assign w_legal = mode ? w_john_legal : w_ring_legal;

  // Feedback bits: straight wrap-around for ring, inverted for Johnson.
  assign w_fb_low  = mode ? ~r_count[WIDTH-1] : r_count[WIDTH-1];
  assign w_fb_high = mode ? ~r_count[0]       : r_count[0];

  always_comb begin
    w_shifted = r_count;
    if (dir == 1'b0) begin
      w_shifted = {r_count[WIDTH-2:0], w_fb_low};
    end else begin
      w_shifted = {w_fb_high, r_count[WIDTH-1:1]};
    end
  end

  // Next-state selection: load, then enabled advance/correction, then hold.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      w_count_nxt = load_val;
    end else if (en) begin
      if (w_legal) begin
        w_count_nxt = w_shifted;
        w_wrap_nxt  = (w_shifted == HOME);
      end else begin
        w_count_nxt = HOME;
        w_err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= HOME;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb/tb_ring_johnson_counter.sv - self-checking bench for ring_johnson_counter (WIDTH 4, 2, 5, 8)

module tb_ring_johnson_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic        mode;
  logic        dir;
  logic        load;
  logic [31:0] load_val;

  logic [3:0] c4;
  logic [1:0] c2;
  logic [4:0] c5;
  logic [7:0] c8;
  logic       w4, w2, w5, w8;
  logic       e4, e2, e5, e8;

  int vectors;
  int miscompares;

  int widths [4] = '{4, 2, 5, 8};
  logic [31:0] mdl [4];

  typedef struct {
    int          idx;
    logic [31:0] c;
    logic        w;
    logic        e;
  } exp_t;

  exp_t sbq [$];

  ring_johnson_counter #(.WIDTH(4)) d4 (.clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val[3:0]), .count(c4), .wrap(w4), .err(e4));
  ring_johnson_counter #(.WIDTH(2)) d2 (.clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val[1:0]), .count(c2), .wrap(w2), .err(e2));
  ring_johnson_counter #(.WIDTH(5)) d5 (.clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val[4:0]), .count(c5), .wrap(w5), .err(e5));
  ring_johnson_counter #(.WIDTH(8)) d8 (.clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val[7:0]), .count(c8), .wrap(w8), .err(e8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: bit-by-bit loops, independent of the RTL's tricks.
  function automatic void model(input int w, input logic [31:0] cur, input logic m, d, e, l,
                                input logic [31:0] lv, output logic [31:0] nx,
                                output logic wr, output logic er);
    logic [31:0] mask;
    int ones, trans;
    logic legal;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    nx = cur; wr = 1'b0; er = 1'b0;
    if (l) begin
      nx = lv & mask;
    end else if (e) begin
      ones = 0; trans = 0;
      for (int i = 0; i < w; i++) if (cur[i]) ones++;
      for (int i = 0; i < w - 1; i++) if (cur[i] != cur[i+1]) trans++;
      legal = m ? (trans <= 1) : (ones == 1);
      if (!legal) begin
        nx = 32'h1; er = 1'b1;
      end else begin
        nx = '0;
        for (int i = 0; i < w; i++) begin
          if (!d) nx[i] = (i == 0) ? (cur[w-1] ^ m) : cur[i-1];
          else    nx[i] = (i == w - 1) ? (cur[0] ^ m) : cur[i+1];
        end
        wr = (nx == 32'h1);
      end
    end
  endfunction

  function automatic void dut_out(input int idx, output logic [31:0] c, output logic w, output logic e);
    case (idx)
      0: begin c = {28'b0, c4}; w = w4; e = e4; end
      1: begin c = {30'b0, c2}; w = w2; e = e2; end
      2: begin c = {27'b0, c5}; w = w5; e = e5; end
      default: begin c = {24'b0, c8}; w = w8; e = e8; end
    endcase
  endfunction

  // Drive one edge's inputs, push the expectation for every DUT, then
  // pop and compare once the edge has been taken.
  task automatic step(input logic e, input logic l, input logic m, input logic d, input logic [31:0] lv);
    exp_t x;
    logic [31:0] nx, ac;
    logic wr, er, aw, ae;
    @(negedge clk);
    en = e; load = l; mode = m; dir = d; load_val = lv;
    for (int k = 0; k < 4; k++) begin
      model(widths[k], mdl[k], m, d, e, l, lv, nx, wr, er);
      mdl[k] = nx;
      x.idx = k; x.c = nx; x.w = wr; x.e = er;
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      dut_out(x.idx, ac, aw, ae);
      vectors++;
      if (ac !== x.c || aw !== x.w || ae !== x.e) begin
        miscompares++;
        $display("FAIL sb_w%0d: got count=%h wrap=%b err=%b, expected count=%h wrap=%b err=%b",
                 widths[x.idx], ac, aw, ae, x.c, x.w, x.e);
      end
    end
  endtask

  task automatic do_reset();
    logic [31:0] ac;
    logic aw, ae;
    @(negedge clk);
    reset = 1'b0; en = 1'b0; load = 1'b0;
    for (int k = 0; k < 4; k++) mdl[k] = 32'h1;
    #2;
    for (int k = 0; k < 4; k++) begin
      dut_out(k, ac, aw, ae);
      vectors++;
      if (ac !== 32'h1 || aw !== 1'b0 || ae !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_w%0d: got count=%h wrap=%b err=%b, expected count=1 wrap=0 err=0",
                 widths[k], ac, aw, ae);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_ring_sequence();
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       wex [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      vectors++;
      if (c4 !== seq[i] || w4 !== wex[i] || e4 !== 1'b0) begin
        miscompares++;
        $display("FAIL ring_seq[%0d]: got %b wrap=%b err=%b, expected %b wrap=%b err=0",
                 i, c4, w4, e4, seq[i], wex[i]);
      end
    end
  endtask

  task automatic test_johnson_sequence();
    logic [3:0] up [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] dn [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        step(1, 0, 1, d[0], 0);
        vectors++;
        if (c4 !== (d == 0 ? up[i] : dn[i]) || w4 !== (i == 7) || e4 !== 1'b0) begin
          miscompares++;
          $display("FAIL john_seq_dir%0d[%0d]: got %b wrap=%b err=%b, expected %b wrap=%b err=0",
                   d, i, c4, w4, e4, (d == 0 ? up[i] : dn[i]), (i == 7));
        end
      end
    end
  endtask

  task automatic test_load_correct();
    do_reset();
    step(0, 1, 0, 0, 32'h6);
    vectors++;
    if (c4 !== 4'b0110 || w4 !== 1'b0 || e4 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_0110: got %b wrap=%b err=%b, expected 0110 wrap=0 err=0", c4, w4, e4);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (c4 !== 4'b0001 || w4 !== 1'b0 || e4 !== 1'b1) begin
      miscompares++;
      $display("FAIL load_correct: got %b wrap=%b err=%b, expected 0001 wrap=0 err=1", c4, w4, e4);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (c4 !== 4'b0010 || e4 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_after: got %b err=%b, expected 0010 err=0", c4, e4);
    end
    // Ring all-zeros must not lock up.
    step(0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if (c8 !== 8'h01 || e8 !== 1'b1) begin
      miscompares++;
      $display("FAIL ring_zero: got %h err=%b, expected 01 err=1", c8, e8);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    vectors++;
    if (c4 !== 4'b0001 || e4 !== 1'b1 || w4 !== 1'b0) begin
      miscompares++;
      $display("FAIL ring_to_john: got %b wrap=%b err=%b, expected 0001 wrap=0 err=1", c4, w4, e4);
    end
    do_reset();
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if (c4 !== 4'b0001 || e4 !== 1'b1) begin
      miscompares++;
      $display("FAIL john_to_ring: got %b err=%b, expected 0001 err=1", c4, e4);
    end
  endtask

  task automatic test_hold_and_priority();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (c4 !== 4'b0010 || w4 !== 1'b0 || e4 !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %b wrap=%b err=%b, expected 0010 wrap=0 err=0", i, c4, w4, e4);
      end
    end
    step(1, 1, 0, 0, 32'h1);
    vectors++;
    if (c4 !== 4'b0001 || w4 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_wins: got %b wrap=%b, expected 0001 wrap=0", c4, w4);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) mdl[k] = 32'h1;
    #1;
    vectors++;
    if (c4 !== 4'b0001 || w4 !== 1'b0 || e4 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b wrap=%b err=%b, expected 0001 wrap=0 err=0", c4, w4, e4);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (c4 !== 4'b0001 || c8 !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_held: got c4=%b c8=%h, expected 0001 / 01", c4, c8);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_periods();
    int first [4];
    logic [31:0] ac;
    logic aw, ae;
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 2; d++) begin
        do_reset();
        first = '{0, 0, 0, 0};
        for (int n = 1; n <= 16; n++) begin
          step(1, 0, m[0], d[0], 0);
          for (int k = 0; k < 4; k++) begin
            dut_out(k, ac, aw, ae);
            if (aw && first[k] == 0) first[k] = n;
          end
        end
        for (int k = 0; k < 4; k++) begin
          vectors++;
          if (first[k] !== (m == 0 ? widths[k] : 2 * widths[k])) begin
            miscompares++;
            $display("FAIL period_w%0d_m%0d_d%0d: got %0d, expected %0d",
                     widths[k], m, d, first[k], (m == 0 ? widths[k] : 2 * widths[k]));
          end
        end
      end
    end
  endtask

  task automatic test_exhaustive_load();
    int n4, n5, n8;
    int exp4 [2] = '{192, 128};
    int exp5 [2] = '{216, 176};
    int exp8 [2] = '{248, 240};
    for (int m = 0; m < 2; m++) begin
      do_reset();
      n4 = 0; n5 = 0; n8 = 0;
      for (int v = 0; v < 256; v++) begin
        step(0, 1, m[0], 0, v);
        step(1, 0, m[0], 0, 0);
        n4 += int'(e4); n5 += int'(e5); n8 += int'(e8);
      end
      vectors++;
      if (n4 !== exp4[m] || n5 !== exp5[m] || n8 !== exp8[m]) begin
        miscompares++;
        $display("FAIL illegal_count_m%0d: got w4=%0d w5=%0d w8=%0d, expected %0d %0d %0d",
                 m, n4, n5, n8, exp4[m], exp5[m], exp8[m]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_ring_sequence();
    test_johnson_sequence();
    test_load_correct();
    test_mode_switch();
    test_hold_and_priority();
    test_async_reset();
    test_periods();
    test_exhaustive_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
